// File: rtl/exec_line.sv
// exec_line: data-side executor (Acc, AP, data memory, byte I/O).
// Optional EXEC_LINE_CLEAR_MEM_EN zero-fills memory after reset.
module exec_line #(
  parameter int AP_WIDTH    = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int STEP_CYCLES = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [15:0]           Opcode,
  input  logic                  OpcodeReady,
  output logic                  OpcodeAck,
  output logic                  DataZero,
  output logic [AP_WIDTH-1:0]   Ap,
  output logic [DATA_WIDTH-1:0] IoOutData,
  output logic                  IoOutValid,
  input  logic                  IoOutReady,
  input  logic [DATA_WIDTH-1:0] IoInData,
  input  logic                  IoInValid,
  output logic                  IoInReady,
  output logic                  Halted,
  output logic                  Error
);

  localparam int DEPTH = 1 << AP_WIDTH;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_STEP,
    S_WB_READ,
    S_IO_OUT,
    S_IO_IN,
    S_ACK,
    S_WAIT_DROP,
    S_HALT
`ifdef EXEC_LINE_CLEAR_MEM_EN
    , S_CLEAR
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [SW-1:0]         step_q, step_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [AP_WIDTH-1:0]   ap_q, ap_d;
  logic                  zero_q, zero_d;
  logic                  ack_q, ack_d;
  logic                  halted_q, halted_d;
  logic                  error_q, error_d;
`ifdef EXEC_LINE_CLEAR_MEM_EN
  logic [AP_WIDTH-1:0]   clr_q, clr_d;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [AP_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  legal;

  assign legal = (Opcode != 16'd0)
              && ((Opcode & (Opcode - 16'd1)) == 16'd0)
              && (Opcode[15:10] == 6'd0);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    step_d    = step_q;
    acc_d     = acc_q;
    ap_d      = ap_q;
    ack_d     = 1'b0;
    halted_d  = halted_q;
    error_d   = error_q;
    mem_we    = 1'b0;
    mem_addr  = ap_q;
    mem_wdata = acc_q;
`ifdef EXEC_LINE_CLEAR_MEM_EN
    clr_d     = clr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (OpcodeReady) begin
          op_d   = Opcode[4:1];
          step_d = '0;
          if (!legal) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            error_d  = 1'b1;
          end else begin
            unique case (1'b1)
              Opcode[1], Opcode[2]: state_d = S_STEP;
              Opcode[3], Opcode[4]: begin
                // Flush the cached cell before the pointer moves
                state_d = S_STEP;
                mem_we  = 1'b1;
              end
              Opcode[7]: state_d = S_IO_OUT;
              Opcode[8]: state_d = S_IO_IN;
              Opcode[9]: begin
                state_d  = S_HALT;
                halted_d = 1'b1;
              end
              default: state_d = S_ACK;
            endcase
          end
        end
      end
      S_STEP: begin
        if (step_q == STEP_LAST) begin
          if (op_q[0])      acc_d = acc_q + 1'b1;
          else if (op_q[1]) acc_d = acc_q - 1'b1;
          else if (op_q[2]) ap_d  = ap_q + 1'b1;
          else              ap_d  = ap_q - 1'b1;
          state_d = (op_q[0] | op_q[1]) ? S_ACK : S_WB_READ;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_WB_READ: begin
        acc_d   = mem[ap_q];
        state_d = S_ACK;
      end
      S_IO_OUT: begin
        if (IoOutReady) state_d = S_ACK;
      end
      S_IO_IN: begin
        if (IoInValid) begin
          acc_d   = IoInData;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_d   = 1'b1;
        state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (!OpcodeReady) state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
`ifdef EXEC_LINE_CLEAR_MEM_EN
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_q;
        mem_wdata = '0;
        clr_d     = clr_q + 1'b1;
        if (clr_q == {AP_WIDTH{1'b1}}) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    zero_d = (acc_d == '0);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
`ifdef EXEC_LINE_CLEAR_MEM_EN
      state_q <= S_CLEAR;
      clr_q   <= '0;
`else
      state_q <= S_IDLE;
`endif
      op_q     <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      ap_q     <= '0;
      zero_q   <= 1'b1;
      ack_q    <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
`ifdef EXEC_LINE_CLEAR_MEM_EN
      clr_q    <= clr_d;
`endif
      state_q  <= state_d;
      op_q     <= op_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      ap_q     <= ap_d;
      zero_q   <= zero_d;
      ack_q    <= ack_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // Memory keeps its contents across reset
  always_ff @(posedge Clk) begin
    if (Rst_n && mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign OpcodeAck  = ack_q;
  assign DataZero   = zero_q;
  assign Ap         = ap_q;
  assign IoOutValid = (state_q == S_IO_OUT);
  assign IoOutData  = IoOutValid ? acc_q : '0;
  assign IoInReady  = (state_q == S_IO_IN);
  assign Halted     = halted_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_exec_line.sv
// tb_exec_line: directed checks of exec_line with STEP_CYCLES=2.
// Define EXEC_LINE_CLEAR_MEM_EN to also cover the clear sequence.
module tb_exec_line;

  localparam logic [15:0] NOP = 16'h0001;
  localparam logic [15:0] INC = 16'h0002;
  localparam logic [15:0] DEC = 16'h0004;
  localparam logic [15:0] RGT = 16'h0008;
  localparam logic [15:0] LFT = 16'h0010;
  localparam logic [15:0] LBR = 16'h0020;
  localparam logic [15:0] RBR = 16'h0040;
  localparam logic [15:0] OUT = 16'h0080;
  localparam logic [15:0] INP = 16'h0100;
  localparam logic [15:0] HLT = 16'h0200;

  logic        Clk;
  logic        Rst_n;
  logic [15:0] Opcode;
  logic        OpcodeReady;
  logic        OpcodeAck;
  logic        DataZero;
  logic [9:0]  Ap;
  logic [7:0]  IoOutData;
  logic        IoOutValid;
  logic        IoOutReady;
  logic [7:0]  IoInData;
  logic        IoInValid;
  logic        IoInReady;
  logic        Halted;
  logic        Error;

  int checks = 0;
  int errors = 0;
  int lat;
  int acks;
  logic [7:0] od;
  logic dz;

  exec_line #(
    .AP_WIDTH(10), .DATA_WIDTH(8), .STEP_CYCLES(2)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Opcode(Opcode), .OpcodeReady(OpcodeReady),
    .OpcodeAck(OpcodeAck), .DataZero(DataZero), .Ap(Ap),
    .IoOutData(IoOutData), .IoOutValid(IoOutValid),
    .IoOutReady(IoOutReady),
    .IoInData(IoInData), .IoInValid(IoInValid),
    .IoInReady(IoInReady),
    .Halted(Halted), .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    OpcodeReady = 1'b0;
    Opcode = '0;
    IoOutReady = 1'b0;
    IoInValid = 1'b0;
    IoInData = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
`ifdef EXEC_LINE_CLEAR_MEM_EN
    OpcodeReady = 1'b1;
    Opcode = NOP;
    acks = 0;
    repeat (1 << 10) begin
      @(posedge Clk); #1;
      if (OpcodeAck) acks++;
    end
    check("clear_no_ack", 32'(acks), 32'd0);
    OpcodeReady = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("clear_cell", 32'(DataZero), 32'd1);
`endif
  endtask

  // Issue one opcode, wait (bounded) for its ack, then drop ready
  task automatic run_op(input logic [15:0] op, output int l,
                        output logic [7:0] o, output logic z);
    Opcode = op;
    OpcodeReady = 1'b1;
    l = 0;
    o = '0;
    @(posedge Clk); #1;
    if (IoOutValid) o = IoOutData;
    while (!OpcodeAck && l < 40) begin
      @(posedge Clk); #1;
      l++;
      if (IoOutValid) o = IoOutData;
    end
    z = DataZero;
    check("ack_seen", 32'(OpcodeAck), 32'd1);
    OpcodeReady = 1'b0;
    @(posedge Clk); #1;
    check("ack_pulse", 32'(OpcodeAck), 32'd0);
  endtask

  task automatic issue_no_ack(input logic [15:0] op, output int n);
    Opcode = op;
    OpcodeReady = 1'b1;
    n = 0;
    repeat (8) begin
      @(posedge Clk); #1;
      if (OpcodeAck) n++;
    end
    OpcodeReady = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    do_reset();
    check("rst_ap", 32'(Ap), 32'd0);
    check("rst_ack", 32'(OpcodeAck), 32'd0);
    check("rst_zero", 32'(DataZero), 32'd1);
    check("rst_oval", 32'(IoOutValid), 32'd0);
    check("rst_odata", 32'(IoOutData), 32'd0);
    check("rst_irdy", 32'(IoInReady), 32'd0);
    check("rst_halt", 32'(Halted), 32'd0);
    check("rst_err", 32'(Error), 32'd0);

    IoOutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(INC, lat, od, dz);
      check("inc_lat", 32'(lat), 32'd3);
    end
    check("inc3_zero", 32'(DataZero), 32'd0);
    run_op(OUT, lat, od, dz);
    check("out_lat", 32'(lat), 32'd2);
    check("inc3_acc", 32'(od), 32'd3);

    do_reset();
    IoOutReady = 1'b1;
    run_op(DEC, lat, od, dz);
    check("dec_lat", 32'(lat), 32'd3);
    check("dec_zero", 32'(dz), 32'd0);
    run_op(OUT, lat, od, dz);
    check("dec_wrap", 32'(od), 32'hff);
    run_op(INC, lat, od, dz);
    check("inc_wrap_zero", 32'(dz), 32'd1);
    run_op(NOP, lat, od, dz);
    check("nop_lat", 32'(lat), 32'd1);
    run_op(LBR, lat, od, dz);
    check("lbr_lat", 32'(lat), 32'd1);
    run_op(RBR, lat, od, dz);
    check("rbr_lat", 32'(lat), 32'd1);
    check("rbr_zero", 32'(dz), 32'd1);

    do_reset();
    IoOutReady = 1'b1;
    IoInValid = 1'b1;
    IoInData = 8'h00;
    run_op(INC, lat, od, dz);
    run_op(RGT, lat, od, dz);
    check("rgt_lat", 32'(lat), 32'd4);
    check("rgt_ap", 32'(Ap), 32'd1);
    run_op(INP, lat, od, dz);
    check("in_lat", 32'(lat), 32'd2);
    run_op(INC, lat, od, dz);
    run_op(INC, lat, od, dz);
    run_op(LFT, lat, od, dz);
    check("lft_lat", 32'(lat), 32'd4);
    check("lft_ap", 32'(Ap), 32'd0);
    run_op(OUT, lat, od, dz);
    check("cell0", 32'(od), 32'd1);
    run_op(RGT, lat, od, dz);
    check("rgt2_ap", 32'(Ap), 32'd1);
    run_op(OUT, lat, od, dz);
    check("cell1", 32'(od), 32'd2);
    run_op(LFT, lat, od, dz);
    run_op(LFT, lat, od, dz);
    check("ap_wrap", 32'(Ap), 32'h3ff);

    do_reset();
    IoOutReady = 1'b1;
    run_op(INC, lat, od, dz);
    IoOutReady = 1'b0;
    Opcode = OUT;
    OpcodeReady = 1'b1;
    @(posedge Clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("out_hold_v", 32'(IoOutValid), 32'd1);
      check("out_hold_d", 32'(IoOutData), 32'd1);
      check("out_hold_ack", 32'(OpcodeAck), 32'd0);
      @(posedge Clk); #1;
    end
    IoOutReady = 1'b1;
    @(posedge Clk); #1;
    IoOutReady = 1'b0;
    check("out_hs_v", 32'(IoOutValid), 32'd0);
    check("out_hs_ack", 32'(OpcodeAck), 32'd0);
    @(posedge Clk); #1;
    check("out_ack", 32'(OpcodeAck), 32'd1);
    OpcodeReady = 1'b0;
    @(posedge Clk); #1;

    IoInData = 8'h00;
    IoInValid = 1'b1;
    run_op(INP, lat, od, dz);
    check("in0_lat", 32'(lat), 32'd2);
    check("in0_zero", 32'(dz), 32'd1);
    check("in_rdy_drop", 32'(IoInReady), 32'd0);

    Opcode = INC;
    OpcodeReady = 1'b1;
    lat = 0;
    @(posedge Clk); #1;
    while (!OpcodeAck && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("held_first_ack", 32'(OpcodeAck), 32'd1);
    acks = 0;
    repeat (8) begin
      @(posedge Clk); #1;
      if (OpcodeAck) acks++;
    end
    check("held_no_reexec", 32'(acks), 32'd0);
    OpcodeReady = 1'b0;
    @(posedge Clk); #1;
    IoOutReady = 1'b1;
    run_op(OUT, lat, od, dz);
    check("held_acc", 32'(od), 32'd1);

    issue_no_ack(16'h0003, acks);
    check("ill2_acks", 32'(acks), 32'd0);
    check("ill2_halt", 32'(Halted), 32'd1);
    check("ill2_err", 32'(Error), 32'd1);
    issue_no_ack(NOP, acks);
    check("halted_no_ack", 32'(acks), 32'd0);
    do_reset();
    check("unhalt", 32'(Halted), 32'd0);
    check("unerr", 32'(Error), 32'd0);
    issue_no_ack(HLT, acks);
    check("halt_acks", 32'(acks), 32'd0);
    check("halt_halt", 32'(Halted), 32'd1);
    check("halt_err", 32'(Error), 32'd0);
    do_reset();
    issue_no_ack(16'h0400, acks);
    check("resv_err", 32'(Error), 32'd1);
    do_reset();
    issue_no_ack(16'h0000, acks);
    check("zero_op_err", 32'(Error), 32'd1);
    check("zero_op_acks", 32'(acks), 32'd0);

    do_reset();
    run_op(RGT, lat, od, dz);
    check("pre_ap", 32'(Ap), 32'd1);
    Opcode = RGT;
    OpcodeReady = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    OpcodeReady = 1'b0;
    @(posedge Clk); #1;
    check("mid_rst_ap", 32'(Ap), 32'd0);
    check("mid_rst_ack", 32'(OpcodeAck), 32'd0);
    check("mid_rst_zero", 32'(DataZero), 32'd1);
    @(posedge Clk); #1;
    check("mid_rst_ap2", 32'(Ap), 32'd0);
    Rst_n = 1'b1;

    do_reset();
    Opcode = OUT;
    OpcodeReady = 1'b1;
    @(posedge Clk); #1;
    check("pend_out_v", 32'(IoOutValid), 32'd1);
    Rst_n = 1'b0;
    OpcodeReady = 1'b0;
    @(posedge Clk); #1;
    check("rst_out_v", 32'(IoOutValid), 32'd0);
    check("rst_out_d", 32'(IoOutData), 32'd0);
    do_reset();
    Opcode = INP;
    OpcodeReady = 1'b1;
    @(posedge Clk); #1;
    check("pend_in_r", 32'(IoInReady), 32'd1);
    Rst_n = 1'b0;
    OpcodeReady = 1'b0;
    @(posedge Clk); #1;
    check("rst_in_r", 32'(IoInReady), 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
